// File: rtl/cdr_dlf_pkg.sv
// cdr_dlf_pkg: shared types and saturating arithmetic helpers for the
// bang-bang CDR digital loop filter.
// Contents: gear_e (ACQ/TRK), arith_t (wide signed working type),
//           clamp() and sat_add() helpers.
package cdr_dlf_pkg;

  typedef enum logic [0:0] {
    GEAR_ACQ = 1'b0,
    GEAR_TRK = 1'b1
  } gear_e;

  // Working width for filter arithmetic: wide enough that no Nbit-sized
  // sum plus a shifted vote can overflow before it is clamped.
  localparam int unsigned ARITH_W = 64;
  typedef logic signed [ARITH_W-1:0] arith_t;

  function automatic arith_t clamp(input arith_t x, input arith_t lo, input arith_t hi);
    arith_t r;
    if (x < lo) begin
      r = lo;
    end else if (x > hi) begin
      r = hi;
    end else begin
      r = x;
    end
    return r;
  endfunction

  function automatic arith_t sat_add(input arith_t a, input arith_t b,
                                     input arith_t lo, input arith_t hi);
    return clamp(a + b, lo, hi);
  endfunction

endpackage

// File: rtl/pd_vote_decim.sv
// pd_vote_decim: DECIM-cycle majority-vote decimator for up/dn pulses.
// Ports: clk, rstn (async active-low), up/dn (phase detector early/late),
//        clear (synchronous restart of the vote window),
//        v   (signed vote of the closing window: +1, 0, -1; valid while stb),
//        stb (high on the last cycle of each window, includes that cycle's e).
module pd_vote_decim
  import cdr_dlf_pkg::*;
#(
  parameter int DECIM = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              up,
  input  logic              dn,
  input  logic              clear,
  output logic signed [1:0] v,
  output logic              stb
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DECIM) + 2;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0]        wcnt_r;
  logic signed [AW-1:0] acc_r;
  logic signed [AW-1:0] e_s;
  logic signed [AW-1:0] sum_s;

  // per-cycle error, window sum including this cycle, and its sign
  always_comb begin
    e_s = '0;
    if (up && !dn) begin
      e_s = {{(AW-1){1'b0}}, 1'b1};
    end else if (dn && !up) begin
      e_s = {AW{1'b1}};
    end else begin
      e_s = '0;
    end
    sum_s = acc_r + e_s;
    stb   = (wcnt_r == LAST);
    if (sum_s[AW-1]) begin
      v = 2'sb11;
    end else if (sum_s != '0) begin
      v = 2'sb01;
    end else begin
      v = 2'sb00;
    end
  end

  // window position counter and running error accumulator
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_r <= '0;
      acc_r  <= '0;
    end else if (clear || stb) begin
      wcnt_r <= '0;
      acc_r  <= '0;
    end else begin
      wcnt_r <= wcnt_r + CW'(1);
      acc_r  <= sum_s;
    end
  end

endmodule

// File: rtl/bb_dlf_gearshift.sv
// bb_dlf_gearshift: bang-bang CDR loop filter with vote decimation,
// two-gear shift gains, saturating integrator and windowed lock detector.
// Ports: clk, rstn (async active-low), up/dn (phase detector),
//        force_acq (sync restart of gear/lock logic, keeps integ/out),
//        out (DCO control word), gear (0=ACQ,1=TRK), locked, vote_stb
//        (one-cycle pulse in the cycle out carries a new value).
module bb_dlf_gearshift
  import cdr_dlf_pkg::*;
#(
  parameter int              Nbit      = 20,
  parameter logic [Nbit-1:0] OFFSET    = {1'b1, {(Nbit-1){1'b0}}},
  parameter int              DECIM     = 4,
  parameter int              KP_ACQ_SH = 8,
  parameter int              KI_ACQ_SH = 2,
  parameter int              KP_TRK_SH = 6,
  parameter int              KI_TRK_SH = 0,
  parameter int              ACQ_LEN   = 1024,
  parameter int              LOCK_WIN  = 64,
  parameter int              LOCK_THR  = 8,
  parameter int              LOCK_CNT  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            up,
  input  logic            dn,
  input  logic            force_acq,
  output logic [Nbit-1:0] out,
  output logic            gear,
  output logic            locked,
  output logic            vote_stb
);

  localparam int IW  = Nbit + 2;
  localparam int AQW = $clog2(ACQ_LEN + 1);
  localparam int LWW = (LOCK_WIN > 1) ? $clog2(LOCK_WIN) : 1;
  localparam int NW  = $clog2(LOCK_WIN) + 2;
  localparam int GW  = $clog2(LOCK_CNT + 1);

  localparam arith_t OFF_A    = arith_t'(OFFSET);
  localparam arith_t OUT_MAX  = (arith_t'(1) << Nbit) - arith_t'(1);
  localparam arith_t INTEG_LO = -OFF_A;
  localparam arith_t INTEG_HI = OUT_MAX - OFF_A;

  logic signed [1:0]    vote_s;
  logic                 close_s;

  logic [Nbit-1:0]      out_r, out_upd_s, out_nxt_s;
  logic signed [IW-1:0] integ_r, integ_upd_s, integ_nxt_s;
  gear_e                gear_r, gear_nxt_s;
  logic                 locked_r, locked_nxt_s;
  logic                 vote_stb_r, vote_stb_nxt_s;
  logic [AQW-1:0]       acq_cnt_r, acq_cnt_nxt_s;
  logic [LWW-1:0]       lwin_r, lwin_nxt_s;
  logic signed [NW-1:0] net_r, net_nxt_s, net_sum_s;
  logic [GW-1:0]        good_r, good_nxt_s;
  logic                 win_good_s;
  arith_t               vote_ext_s;
  int unsigned          ki_sh_s, kp_sh_s;

  pd_vote_decim #(.DECIM(DECIM)) u_decim (
    .clk   (clk),
    .rstn  (rstn),
    .up    (up),
    .dn    (dn),
    .clear (force_acq),
    .v     (vote_s),
    .stb   (close_s)
  );

  // candidate filter update and lock-window evaluation for the closing vote
  always_comb begin
    vote_ext_s = arith_t'(vote_s);
    if (gear_r == GEAR_TRK) begin
      ki_sh_s = KI_TRK_SH;
      kp_sh_s = KP_TRK_SH;
    end else begin
      ki_sh_s = KI_ACQ_SH;
      kp_sh_s = KP_ACQ_SH;
    end
    // integ bounds keep OFFSET+integ inside the output range on their own;
    // the proportional kick is clamped separately so out never wraps
    integ_upd_s = IW'(sat_add(arith_t'(integ_r), vote_ext_s <<< ki_sh_s, INTEG_LO, INTEG_HI));
    out_upd_s   = Nbit'(clamp(OFF_A + arith_t'(integ_upd_s) + (vote_ext_s <<< kp_sh_s),
                              '0, OUT_MAX));
    net_sum_s   = net_r + NW'(vote_s);
    win_good_s  = (arith_t'(net_sum_s) <= arith_t'(LOCK_THR)) &&
                  (arith_t'(net_sum_s) >= -arith_t'(LOCK_THR));
  end

  // next-state: force_acq outranks a window close, whose vote is then dropped
  always_comb begin
    integ_nxt_s    = integ_r;
    out_nxt_s      = out_r;
    gear_nxt_s     = gear_r;
    acq_cnt_nxt_s  = acq_cnt_r;
    lwin_nxt_s     = lwin_r;
    net_nxt_s      = net_r;
    good_nxt_s     = good_r;
    vote_stb_nxt_s = 1'b0;
    if (force_acq) begin
      gear_nxt_s    = GEAR_ACQ;
      acq_cnt_nxt_s = '0;
      lwin_nxt_s    = '0;
      net_nxt_s     = '0;
      good_nxt_s    = '0;
    end else if (close_s) begin
      integ_nxt_s    = integ_upd_s;
      out_nxt_s      = out_upd_s;
      vote_stb_nxt_s = 1'b1;
      // gains for this strobe were chosen from gear_r; TRK applies next strobe
      if (gear_r == GEAR_ACQ) begin
        acq_cnt_nxt_s = acq_cnt_r + AQW'(1);
        if (acq_cnt_nxt_s == AQW'(ACQ_LEN)) begin
          gear_nxt_s = GEAR_TRK;
        end else begin
          gear_nxt_s = GEAR_ACQ;
        end
      end else begin
        acq_cnt_nxt_s = acq_cnt_r;
      end
      if (lwin_r == LWW'(LOCK_WIN - 1)) begin
        lwin_nxt_s = '0;
        net_nxt_s  = '0;
        if (!win_good_s) begin
          good_nxt_s = '0;
        end else if (good_r == GW'(LOCK_CNT)) begin
          good_nxt_s = good_r;
        end else begin
          good_nxt_s = good_r + GW'(1);
        end
      end else begin
        lwin_nxt_s = lwin_r + LWW'(1);
        net_nxt_s  = net_sum_s;
      end
    end else begin
      vote_stb_nxt_s = 1'b0;
    end
    // evaluated on next-state so gear and lock can rise on the same edge
    locked_nxt_s = (gear_nxt_s == GEAR_TRK) && (good_nxt_s == GW'(LOCK_CNT));
  end

  // state registers; every output is driven straight from a flop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_r      <= OFFSET;
      integ_r    <= '0;
      gear_r     <= GEAR_ACQ;
      locked_r   <= 1'b0;
      vote_stb_r <= 1'b0;
      acq_cnt_r  <= '0;
      lwin_r     <= '0;
      net_r      <= '0;
      good_r     <= '0;
    end else begin
      out_r      <= out_nxt_s;
      integ_r    <= integ_nxt_s;
      gear_r     <= gear_nxt_s;
      locked_r   <= locked_nxt_s;
      vote_stb_r <= vote_stb_nxt_s;
      acq_cnt_r  <= acq_cnt_nxt_s;
      lwin_r     <= lwin_nxt_s;
      net_r      <= net_nxt_s;
      good_r     <= good_nxt_s;
    end
  end

  assign out      = out_r;
  assign gear     = gear_r;
  assign locked   = locked_r;
  assign vote_stb = vote_stb_r;

endmodule

// File: tb/tb_bb_dlf_gearshift.sv
// tb_bb_dlf_gearshift: self-checking bench for bb_dlf_gearshift.
// A narrowed control word (12 bits) keeps both rails reachable in a short run.
module tb_bb_dlf_gearshift;

  localparam int NB   = 12;
  localparam int OFF  = 2048;
  localparam int MAXV = 4095;
  localparam int DEC  = 4;
  localparam int KPA  = 8;
  localparam int KIA  = 2;
  localparam int KPT  = 6;
  localparam int KIT  = 0;
  localparam int ACQ  = 1024;
  localparam int LW   = 64;
  localparam int THR  = 8;
  localparam int LC   = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          up, dn, force_acq;
  logic [NB-1:0] out;
  logic          gear, locked, vote_stb;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  bb_dlf_gearshift #(
    .Nbit(NB), .OFFSET(12'd2048), .DECIM(DEC),
    .KP_ACQ_SH(KPA), .KI_ACQ_SH(KIA), .KP_TRK_SH(KPT), .KI_TRK_SH(KIT),
    .ACQ_LEN(ACQ), .LOCK_WIN(LW), .LOCK_THR(THR), .LOCK_CNT(LC)
  ) dut (
    .clk(clk), .rstn(rstn), .up(up), .dn(dn), .force_acq(force_acq),
    .out(out), .gear(gear), .locked(locked), .vote_stb(vote_stb)
  );

  always #5 clk = ~clk;

  // behavioural model state, plain integers
  typedef struct packed {
    int wpos; int wsum; int integ; int outv; int stb;
    int acqn; int gear; int lwn; int net; int good; int locked;
  } mst_t;

  mst_t m;

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic mst_t mreset();
    mst_t r;
    r = '0;
    r.outv = OFF;
    return r;
  endfunction

  function automatic mst_t mnext(input mst_t s, input logic u, input logic d, input logic f);
    mst_t n;
    int e, sum, v, ki, kp;
    n = s;
    n.stb = 0;
    if (f) begin
      n.gear = 0; n.acqn = 0; n.wpos = 0; n.wsum = 0;
      n.lwn = 0; n.net = 0; n.good = 0; n.locked = 0;
    end else begin
      e = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      sum = s.wsum + e;
      if (s.wpos == DEC - 1) begin
        v  = (sum > 0) ? 1 : ((sum < 0) ? -1 : 0);
        ki = (s.gear != 0) ? (1 << KIT) : (1 << KIA);
        kp = (s.gear != 0) ? (1 << KPT) : (1 << KPA);
        n.integ = clampi(s.integ + v * ki, -OFF, MAXV - OFF);
        n.outv  = clampi(OFF + n.integ + v * kp, 0, MAXV);
        n.stb = 1; n.wpos = 0; n.wsum = 0;
        if (s.gear == 0) begin
          n.acqn = s.acqn + 1;
          if (n.acqn >= ACQ) n.gear = 1;
        end
        n.lwn = s.lwn + 1;
        n.net = s.net + v;
        if (n.lwn == LW) begin
          if (n.net <= THR && n.net >= -THR) n.good = (s.good < LC) ? s.good + 1 : LC;
          else n.good = 0;
          n.lwn = 0; n.net = 0;
        end
        n.locked = (n.gear == 1 && n.good == LC) ? 1 : 0;
      end else begin
        n.wpos = s.wpos + 1;
        n.wsum = sum;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= mreset();
    else       m <= mnext(m, up, dn, force_acq);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("out",      int'(out),      m.outv);
      chk("gear",     int'(gear),     m.gear);
      chk("locked",   int'(locked),   m.locked);
      chk("vote_stb", int'(vote_stb), m.stb);
    end
  end

  task automatic step(input logic u, input logic d, input logic f);
    up = u; dn = d; force_acq = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    up = 1'b0; dn = 1'b0; force_acq = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic alt(input int n);
    for (int i = 0; i < n; i++) step((i % 2) == 0, (i % 2) != 0, 1'b0);
  endtask

  initial begin
    int cnt;
    int out_hold;
    up = 1'b0; dn = 1'b0; force_acq = 1'b0; rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_out", int'(out), 2048);
    chk("rst_gear", int'(gear), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_stb", int'(vote_stb), 0);
    chk_on = 1'b1;

    // first two strobes with up held
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("up_strobe1", int'(out), 2308);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("up_strobe2", int'(out), 2312);

    // balanced input: zero votes, strobe every DECIM cycles
    do_reset();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) step(1'b1, 1'b1, 1'b0);
      else                           step(1'b0, 1'b0, 1'b0);
      if (vote_stb) cnt++;
    end
    chk("zero_vote_out", int'(out), 2048);
    chk("stb_count", cnt, 10);

    // lower rail, then recovery
    do_reset();
    repeat (2400) step(1'b0, 1'b1, 1'b0);
    chk("floor_hold", int'(out), 0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("floor_recover", int'(out), 260);

    // upper rail
    do_reset();
    repeat (2400) step(1'b1, 1'b0, 1'b0);
    chk("ceiling_hold", int'(out), 4095);

    // gear shift and lock on alternating input
    do_reset();
    alt(4092);
    chk("gear_before", int'(gear), 0);
    alt(4);
    chk("gear_after", int'(gear), 1);
    chk("locked_after", int'(locked), 1);
    repeat (252) step(1'b1, 1'b0, 1'b0);
    chk("locked_hold", int'(locked), 1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("locked_drop", int'(locked), 0);

    // relock, then force_acq
    alt(1024);
    chk("relocked", int'(locked), 1);
    out_hold = int'(out);
    step(1'b1, 1'b0, 1'b1);
    chk("force_gear", int'(gear), 0);
    chk("force_locked", int'(locked), 0);
    chk("force_out", int'(out), out_hold);
    alt(4092);
    chk("regear_before", int'(gear), 0);
    alt(4);
    chk("regear_after", int'(gear), 1);
    chk("relock_after", int'(locked), 1);

    // randomized traffic with occasional restarts
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);

    // asynchronous reset mid-window
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("async_out", int'(out), 2048);
    chk("async_gear", int'(gear), 0);
    chk("async_locked", int'(locked), 0);
    chk("async_stb", int'(vote_stb), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
      if (vote_stb && cnt == 0) cnt = i;
    end
    chk("first_stb_after_rst", cnt, 4);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bb_dlf_gearshift.md
Name: bb_dlf_gearshift

Overview:
- Parametrised successor to the bang-bang CDR digital loop filter. Sits between the Alexander phase detector (up/dn) and the DCO control word.
- Adds four things to the plain proportional/integral filter:
  - a DECIM-cycle majority-vote decimator;
  - two-gear (acquisition/tracking) shift-based gains;
  - saturating arithmetic;
  - a windowed lock detector.
- All gains are power-of-two shifts, so the block is fully synthesizable.

Parameters:
- Nbit, 20, width of the DCO control output
- OFFSET, {1'b1,{(Nbit-1){1'b0}}}, control word at reset and integrator origin
- DECIM, 4, vote window length in clk cycles (>=1)
- KP_ACQ_SH, 8, proportional shift in ACQ (gain 256)
- KI_ACQ_SH, 2, integral shift in ACQ (gain 4)
- KP_TRK_SH, 6, proportional shift in TRK (gain 64)
- KI_TRK_SH, 0, integral shift in TRK (gain 1)
- ACQ_LEN, 1024, number of vote strobes spent in ACQ before switching to TRK
- LOCK_WIN, 64, number of vote strobes per lock-evaluation window
- LOCK_THR, 8, maximum |net vote| over a window for that window to count as good
- LOCK_CNT, 4, number of consecutive good windows required for lock

Ports:
- clk  input  1  recovered clock from DCO; all state updates on posedge
- rstn  input  1  asynchronous, active-low reset
- up  input  1  early indication from phase detector
- dn  input  1  late indication from phase detector
- force_acq  input  1  synchronous restart of gear/lock logic
- out  output  Nbit  DCO control word, unsigned
- gear  output  1  0 = ACQ, 1 = TRK
- locked  output  1  lock flag
- vote_stb  output  1  one-cycle pulse on the cycle out updates

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values: out = OFFSET, integ = 0, gear = 0, locked = 0, vote_stb = 0. All counters are cleared.
- Per-cycle error e:
  - up & !dn -> +1
  - dn & !up -> -1
  - both set or neither set -> 0
- Decimator:
  - Counter wcnt runs 0..DECIM-1; signed accumulator acc has width clog2(DECIM)+2.
  - On the cycle with wcnt == DECIM-1, the sum includes that cycle's e.
  - v = sign(sum) in {-1, 0, +1}. acc clears and vote_stb = 1 on the following cycle (registered).
- Filter update, on the edge that closes a window:
  - integ (signed, Nbit+2 bits) <= sat(integ + (v << KI_SH)).
  - out <= clamp(OFFSET + integ_new + (v << KP_SH), 0, 2^Nbit - 1).
  - KI_SH and KP_SH come from the current gear. Latency from last vote cycle to out is 1 clk.
- Saturation:
  - integ is clamped to [-OFFSET, 2^Nbit - 1 - OFFSET].
  - out never wraps; at either bound it holds with further same-sign votes.
- Gear FSM, states ACQ and TRK:
  - ACQ -> TRK when the strobe counter reaches ACQ_LEN.
  - TRK is sticky until force_acq or reset.
  - When force_acq = 1: state <- ACQ; strobe counter, decimator, and all lock counters clear; locked <- 0. integ and out are retained.
- Lock detector:
  - net is a signed sum of v over LOCK_WIN strobes.
  - At window close: if |net| <= LOCK_THR, good count increments, saturating at LOCK_CNT; otherwise good count clears.
  - The detector runs in both gears.
  - locked = (gear == TRK) & (good count == LOCK_CNT), registered. A bad window drops locked on the next edge.
- Simultaneous events:
  - force_acq takes priority over a window close in the same cycle; that vote is discarded.
  - A strobe that reaches ACQ_LEN still uses ACQ gains; TRK gains apply from the next strobe.
- rstn asserted mid-window discards the partial vote immediately (asynchronous).

Decomposition:
- Package cdr_dlf_pkg:
  - gear enum {GEAR_ACQ, GEAR_TRK};
  - signed saturating-add function;
  - clamp function.
- One sub-module, pd_vote_decim (DECIM parameter): inputs up, dn, clear; outputs v[1:0] and stb.
- The top holds the filter arithmetic, gear FSM and lock detector.

Test Plan:
- Reset with rstn low -> out = 524288, gear = 0, locked = 0, vote_stb = 0. Hold up = 1 for 4 cycles -> after first strobe out = 524548 (integ 4); after second strobe out = 524552.
- up = dn = 1, or both 0, for 40 cycles -> v = 0 each window; out stays at 524288; vote_stb pulses every 4 cycles.
- Constant dn from reset -> out decreases monotonically, reaches 0 and holds; no wrap to 2^20 - 1. Then switching to constant up -> out rises on the next strobe.
- Alternating up/dn every cycle -> gear = 1 at strobe 1024 and locked = 1 on the same registered update. Then drive constant up for 64 strobes -> locked = 0 at that window close.
- Pulse force_acq while locked -> gear = 0 and locked = 0 next cycle; out unchanged. With alternating input continued, TRK and locked reassert 1024 strobes later.
- Assert rstn low mid-window (wcnt = 2) -> all outputs return to reset values asynchronously; first strobe after release occurs 4 cycles later.
